// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle between decode, the issue controller, the registered ALU and the writeback consumer.
// master = controller side, slave = environment side (decode, ALU, writeback consumer).
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 5
) ();
    // Both handshakes (in_*, wb_*): a beat transfers on a rising CLOCK edge where valid&ready;
    // the producer holds its payload stable while valid&!ready; ready never depends on valid.
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opselect;
    logic [2:0]        in_operation;
    logic [31:0]       in_src1;
    logic [31:0]       in_src2;
    logic [TAG_W-1:0]  in_dest;

    logic              alu_enable;
    logic [2:0]        alu_opselect;
    logic [2:0]        alu_operation;
    logic [31:0]       alu_in1;
    logic [31:0]       alu_in2;
    logic [31:0]       alu_result;
    logic              alu_carry;

    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_data;
    logic              wb_carry;
    logic [TAG_W-1:0]  wb_dest;
    logic              wb_err;

    modport master (
        input  in_valid, in_opselect, in_operation, in_src1, in_src2, in_dest,
        output in_ready,
        output alu_enable, alu_opselect, alu_operation, alu_in1, alu_in2,
        input  alu_result, alu_carry,
        output wb_valid, wb_data, wb_carry, wb_dest, wb_err,
        input  wb_ready
    );

    modport slave (
        output in_valid, in_opselect, in_operation, in_src1, in_src2, in_dest,
        input  in_ready,
        input  alu_enable, alu_opselect, alu_operation, alu_in1, alu_in2,
        output alu_result, alu_carry,
        input  wb_valid, wb_data, wb_carry, wb_dest, wb_err,
        output wb_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 1-cycle registered ALU: op queue, enable windows, writeback register.
// Optional statistics counters are enabled with `define ALU_ISSUE_CTRL_STATS_EN.
module alu_issue_ctrl #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
`ifdef ALU_ISSUE_CTRL_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                CLOCK,
    input  logic                RESET,
    alu_issue_ctrl_if.master    bus,
    output logic                busy,
    output logic [2:0]          state_dbg
`ifdef ALU_ISSUE_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]    stat_issued,
    output logic [CNT_W-1:0]    stat_stall,
    output logic [CNT_W-1:0]    stat_illegal
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, ISSUE2, CAPT, HOLD} state_t;

    typedef struct packed {
        logic [2:0]       opsel;
        logic [2:0]       op;
        logic [31:0]      src1;
        logic [31:0]      src2;
        logic [TAG_W-1:0] dest;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, nxt_ptr, issue_idx;
    logic [PTR_W:0]   count;
    logic             push, pop, load_alu, use_second, capture, wb_free, head_err;
    state_t           state, state_nxt;

    function automatic logic is_legal(input logic [2:0] sel);
        return (sel == 3'b001) || (sel == 3'b101);
    endfunction

    assign nxt_ptr      = rd_ptr + PTR_W'(1);
    assign bus.in_ready = (count != (PTR_W+1)'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    assign wb_free      = !bus.wb_valid | bus.wb_ready;
    assign head_err     = !is_legal(mem[rd_ptr].opsel);
    assign issue_idx    = use_second ? nxt_ptr : rd_ptr;
    assign busy         = (count != '0) | (state != IDLE) | bus.wb_valid;
    assign state_dbg    = state;

    // The head stays queued until its result is captured, so the capture path
    // can issue the entry behind it in the same cycle.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        load_alu   = 1'b0;
        use_second = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    if (!head_err) begin
                        state_nxt = ISSUE;
                        load_alu  = 1'b1;
                    end else begin
                        state_nxt = CAPT;
                    end
                end
            end
            ISSUE: begin
                if (mem[rd_ptr].opsel == 3'b001 && mem[rd_ptr].op == 3'b001)
                    state_nxt = ISSUE2;
                else
                    state_nxt = CAPT;
            end
            ISSUE2: state_nxt = CAPT;
            CAPT, HOLD: begin
                if (wb_free) begin
                    capture = 1'b1;
                    pop     = 1'b1;
                    if (count > (PTR_W+1)'(1) && is_legal(mem[nxt_ptr].opsel)) begin
                        state_nxt  = ISSUE;
                        load_alu   = 1'b1;
                        use_second = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (push) mem[wr_ptr] <= '{bus.in_opselect, bus.in_operation,
                                   bus.in_src1, bus.in_src2, bus.in_dest};
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= nxt_ptr;
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ALU drive: enable tracks the issue states; operands only change on a new issue.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            bus.alu_enable    <= 1'b0;
            bus.alu_opselect  <= '0;
            bus.alu_operation <= '0;
            bus.alu_in1       <= '0;
            bus.alu_in2       <= '0;
        end else begin
            bus.alu_enable <= (state_nxt == ISSUE) || (state_nxt == ISSUE2);
            if (load_alu) begin
                bus.alu_opselect  <= mem[issue_idx].opsel;
                bus.alu_operation <= mem[issue_idx].op;
                bus.alu_in1       <= mem[issue_idx].src1;
                bus.alu_in2       <= mem[issue_idx].src2;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            bus.wb_valid <= 1'b0;
            bus.wb_data  <= '0;
            bus.wb_carry <= 1'b0;
            bus.wb_dest  <= '0;
            bus.wb_err   <= 1'b0;
        end else if (capture) begin
            bus.wb_valid <= 1'b1;
            bus.wb_data  <= head_err ? 32'd0 : bus.alu_result;
            bus.wb_carry <= head_err ? 1'b0 : bus.alu_carry;
            bus.wb_dest  <= mem[rd_ptr].dest;
            bus.wb_err   <= head_err;
        end else if (bus.wb_ready) begin
            bus.wb_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_CTRL_STATS_EN
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            stat_issued  <= '0;
            stat_stall   <= '0;
            stat_illegal <= '0;
        end else begin
            if (bus.wb_valid && bus.wb_ready && stat_issued != '1)
                stat_issued <= stat_issued + CNT_W'(1);
            if (state == HOLD && stat_stall != '1)
                stat_stall <= stat_stall + CNT_W'(1);
            if (capture && head_err && stat_illegal != '1)
                stat_illegal <= stat_illegal + CNT_W'(1);
        end
    end
`endif

endmodule
